// File: rtl/module2_coarse_cfo_mul_pipe.sv
// Pipelined signed x (signed|unsigned) multiplier for the coarse-CFO path.
// Exact product, optional round-half-up right shift, then saturate or wrap to dout_WIDTH.
module module2_coarse_cfo_mul_pipe #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 32,
    parameter int din1_WIDTH  = 28,
    parameter int din1_SIGNED = 0,
    parameter int dout_WIDTH  = 48,
    parameter int SHIFT       = 0,
    parameter int SAT         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    // One extra product bit covers signed x zero-extended unsigned; one more keeps the rounding add exact.
    localparam int P  = din0_WIDTH + din1_WIDTH + 1;
    localparam int RW = P + 1;
    localparam logic [RW-1:0]         RND  = (RW'(1) << SHIFT) >> 1;
    localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
    localparam logic [dout_WIDTH-1:0] DMAX = ~DMIN;

    if (NUM_STAGE < 1 || NUM_STAGE > 4 || ID < 0) begin : g_bad_param
        $error("module2_coarse_cfo_mul_pipe: NUM_STAGE must be 1..4 and ID non-negative");
    end

    function automatic logic signed [P-1:0] mul(input logic [din0_WIDTH-1:0] a,
                                                input logic [din1_WIDTH-1:0] b);
        logic signed [P-1:0] ax;
        logic signed [P-1:0] bx;
        ax = P'($signed(a));
        if (din1_SIGNED != 0) bx = P'($signed(b));
        else                  bx = P'(b);
        return ax * bx;
    endfunction

    function automatic logic signed [RW-1:0] rnd(input logic signed [P-1:0] p);
        logic signed [RW-1:0] px;
        px = RW'(p);
        return (px + $signed(RND)) >>> SHIFT;
    endfunction

    // Returns {ovf, dout}; r fits when every bit from dout_WIDTH-1 upward equals the sign.
    function automatic logic [dout_WIDTH:0] narrow(input logic signed [RW-1:0] r);
        logic signed [RW-1:0]  hi;
        logic                  fits;
        logic [dout_WIDTH-1:0] d;
        hi   = r >>> (dout_WIDTH - 1);
        fits = (hi == '0) || (hi == '1);
        d    = dout_WIDTH'(r);
        if (SAT != 0 && !fits) d = r[RW-1] ? DMIN : DMAX;
        return {!fits, d};
    endfunction

    logic [NUM_STAGE-1:0] vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   vld <= '0;
        else if (ce) vld <= NUM_STAGE'({vld, in_valid});
    end

    assign out_valid = vld[NUM_STAGE-1];

    if (NUM_STAGE == 1) begin : g_s1
        always_ff @(posedge clk or posedge reset) begin
            if (reset)   {ovf, dout} <= '0;
            else if (ce) {ovf, dout} <= narrow(rnd(mul(din0, din1)));
        end
    end else begin : g_sn
        logic [din0_WIDTH-1:0] a_q;
        logic [din1_WIDTH-1:0] b_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
            end else if (ce) begin
                a_q <= din0;
                b_q <= din1;
            end
        end

        if (NUM_STAGE == 2) begin : g_n2
            always_ff @(posedge clk or posedge reset) begin
                if (reset)   {ovf, dout} <= '0;
                else if (ce) {ovf, dout} <= narrow(rnd(mul(a_q, b_q)));
            end
        end else if (NUM_STAGE == 3) begin : g_n3
            logic signed [P-1:0] prod_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prod_q      <= '0;
                    {ovf, dout} <= '0;
                end else if (ce) begin
                    prod_q      <= mul(a_q, b_q);
                    {ovf, dout} <= narrow(rnd(prod_q));
                end
            end
        end else begin : g_n4
            logic signed [P-1:0]  prod_q;
            logic signed [RW-1:0] r_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prod_q      <= '0;
                    r_q         <= '0;
                    {ovf, dout} <= '0;
                end else if (ce) begin
                    prod_q      <= mul(a_q, b_q);
                    r_q         <= rnd(prod_q);
                    {ovf, dout} <= narrow(r_q);
                end
            end
        end
    end

endmodule

// File: doc/module2_coarse_cfo_mul_pipe.md
Name: module2_coarse_cfo_mul_pipe

Overview:
- Parametrised, pipelined multiplier for the coarse-CFO datapath. Signed din0 times din1, where din1 is signed or zero-extended unsigned.
- Optional rounding right-shift and saturation narrow the full product to dout_WIDTH.
- A valid bit travels alongside the data, and a global clock-enable stalls the whole pipe.
- Successor to the fixed single-cycle 32s x 28ns -> 48 multiplier; used where timing needs registered stages and scaled/saturated products.

Parameters:
- ID, 1, instance tag, no functional effect
- NUM_STAGE, 3, pipeline latency in enabled cycles; legal range 1..4
- din0_WIDTH, 32, width of din0 (always signed)
- din1_WIDTH, 28, width of din1
- din1_SIGNED, 0, 1 = din1 is two's complement, 0 = din1 is unsigned (zero-extended)
- dout_WIDTH, 48, output width
- SHIFT, 0, arithmetic right shift applied to the product; 0..din0_WIDTH+din1_WIDTH-1
- SAT, 1, 1 = saturate to dout_WIDTH, 0 = wrap (truncate MSBs)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when 0 all pipeline registers hold
- in_valid  in  1  din0/din1 qualify this cycle (sampled only when ce=1)
- din0  in  din0_WIDTH  signed multiplicand
- din1  in  din1_WIDTH  multiplier, signedness per din1_SIGNED
- out_valid  out  1  dout/ovf valid
- dout  out  dout_WIDTH  scaled, rounded, saturated product
- ovf  out  1  1 when the result was clipped (SAT=1) or wrapped (SAT=0); qualified by out_valid

Behaviour:
- Reset: asynchronous, active-high.
  - All stage registers, out_valid, dout and ovf go to 0 immediately.
  - In-flight data is discarded.
  - The first capture after release happens on the first rising edge with ce=1.
- Full product width P = din0_WIDTH+din1_WIDTH+1 (extra bit covers signed x zero-extended unsigned). The product is exact, with no intermediate truncation.
- Rounding when SHIFT>0: r = (prod + 2^(SHIFT-1)) >>> SHIFT.
  - Arithmetic shift, round-half-toward-+inf.
  - Computed at P+1 bits so the add cannot overflow.
  - SHIFT=0: r = prod.
- Narrowing to dout_WIDTH:
  - SAT=1: r > 2^(dout_WIDTH-1)-1 gives dout = max positive and ovf=1. r < -2^(dout_WIDTH-1) gives dout = min negative and ovf=1. Otherwise dout = r, ovf=0.
  - SAT=0: dout = r[dout_WIDTH-1:0]; ovf=1 iff r does not fit.
  - If dout_WIDTH >= the width of r, dout is sign-extended and ovf is always 0.
- Pipeline, NUM_STAGE=N:
  - Stage 1 registers inputs and in_valid.
  - Multiply, round and saturate are distributed over the remaining stages.
  - The output register is always the final stage.
  - N=1: the combinational multiply/round/saturate feeds a single output register.
  - Latency is exactly N rising edges with ce=1. Throughput is one sample per enabled cycle.
- ce=0: every register, valid bits included, holds its value. out_valid/dout/ovf stay constant through the stall.
- in_valid=0 with ce=1: a bubble propagates (valid bit 0). The data registers may load don't-care values but dout is only meaningful when out_valid=1.
- Simultaneous reset and ce: reset dominates.
- No backpressure. The consumer must accept on every out_valid=1 cycle or drop ce.

Test Plan:
- Defaults; din0=-3, din1=5, in_valid=1 for one cycle, ce=1 -> out_valid=1 exactly 3 cycles later with dout=-15 (0xFFFF_FFFF_FFF1), ovf=0; out_valid=0 on all other cycles.
- Defaults; din0=0x7FFFFFFF, din1=0xFFFFFFF -> dout=0x7FFF_FFFF_FFFF, ovf=1. Then din0=0x80000000, din1=0xFFFFFFF -> dout=0x8000_0000_0000, ovf=1. With SAT=0, the same first input gives dout = low 48 bits of the exact product and ovf=1.
- SHIFT=4, dout_WIDTH=16; (din0,din1) = (-24,1), (-25,1), (24,1), (8,1) -> dout = -1, -2, 2 (1.5 rounds up), 1 (0.5 rounds up).
- din1_SIGNED=1, din1_WIDTH=28; din0=7, din1=0xFFFFFFF (=-1) -> dout=-7. Same inputs with din1_SIGNED=0 -> dout=7*(2^28-1)=0x6FFFFFF9.
- Streaming 10 consecutive samples with ce deasserted for 2 cycles mid-stream -> outputs appear in order with correct values; each output delayed by exactly the stall length; out_valid frozen during the stall.
- Assert reset asynchronously mid-clock while 3 samples are in flight -> out_valid/dout/ovf go to 0 before the next edge. No stale sample emerges after release. A new sample emerges NUM_STAGE enabled cycles after capture.
